// File: rtl/coproc_sequencer.sv
// coproc_sequencer: instruction FIFO feeding an IDLE/DECODE/EXEC dispatcher.
// Memory opcodes go to the memory unit, arithmetic opcodes to the ALU, each
// through a held start / done handshake. Adds backpressure, illegal-opcode
// detection, an execution timeout and a wrapping retired-instruction counter.
module coproc_sequencer #(
  parameter int INSTR_W = 32,
  parameter int OP_W    = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               mem_start,
  output logic               mem_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data,
  input  logic               mem_done,
  output logic               alu_start,
  output logic [OP_W-1:0]    alu_op,
  input  logic               alu_done,
  input  logic               clr_err,
  output logic               busy,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [CNT_W-1:0]   retired
);

  // Only the decoded fields are stored; bits above them carry no meaning.
  localparam int FW = OP_W + ADDR_W + DATA_W;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_e;

  // Opcode classes: 0 NOP, 1..2 memory, 3..12 ALU, everything else illegal.
  function automatic logic is_nop_op(input logic [OP_W-1:0] op);
    return (op == OP_W'(0));
  endfunction

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_W'(1)) || (op == OP_W'(2));
  endfunction

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_W'(3)) && (op <= OP_W'(12));
  endfunction

  // Upper instruction bits are intentionally ignored.
  generate
    if (INSTR_W > FW) begin : g_unused_hi
      logic unused_hi_bits;
      assign unused_hi_bits = ^instr_in[INSTR_W-1:FW];
    end
  endgenerate

  // ---------------- FIFO ----------------
  logic [FW-1:0] fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          fifo_full, fifo_empty, push, pop;

  // ---------------- FSM / datapath ----------------
  state_e              state_q, state_d;
  logic [FW-1:0]       instr_q, instr_d;
  logic                sel_mem_q, sel_mem_d;
  logic [TW-1:0]       tcnt_q, tcnt_d, tcnt_inc;
  logic                mem_start_q, mem_start_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                alu_start_q, alu_start_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                busy_q, busy_d;

  logic                retire, new_err;
  logic [1:0]          new_code;
  logic                unit_done, timeout_hit;
  logic [OP_W-1:0]     op_f;
  logic [ADDR_W-1:0]   addr_f;
  logic [DATA_W-1:0]   data_f;

  assign fifo_full   = (count_q == (PW+1)'(DEPTH));
  assign fifo_empty  = (count_q == (PW+1)'(0));
  assign instr_ready = !fifo_full;
  assign push        = instr_valid && !fifo_full;
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;

  assign op_f   = instr_q[OP_W-1:0];
  assign addr_f = instr_q[OP_W+ADDR_W-1:OP_W];
  assign data_f = instr_q[FW-1:OP_W+ADDR_W];

  // Only the selected unit's done is observed during EXEC.
  assign unit_done   = sel_mem_q ? mem_done : alu_done;
  assign tcnt_inc    = tcnt_q + TW'(1);
  assign timeout_hit = (tcnt_inc == TW'(TIMEOUT));

  // FIFO pointer and occupancy update; a full FIFO refuses push even on pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; contents are don't-care once pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= instr_in[FW-1:0];
    end
  end

  // Next-state and registered-output logic of the dispatcher.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    sel_mem_d   = sel_mem_q;
    tcnt_d      = tcnt_q;
    mem_start_d = mem_start_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    alu_start_d = alu_start_q;
    alu_op_d    = alu_op_q;
    retire      = 1'b0;
    new_err     = 1'b0;
    new_code    = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          instr_d = fifo_mem_q[rd_ptr_q];
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DECODE: begin
        mem_addr_d = addr_f;
        mem_data_d = data_f;
        alu_op_d   = op_f;
        mem_wr_d   = (op_f == OP_W'(2));
        if (is_nop_op(op_f)) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end else if (is_mem_op(op_f)) begin
          mem_start_d = 1'b1;
          sel_mem_d   = 1'b1;
          tcnt_d      = TW'(0);
          state_d     = ST_EXEC;
        end else if (is_alu_op(op_f)) begin
          alu_start_d = 1'b1;
          sel_mem_d   = 1'b0;
          tcnt_d      = TW'(0);
          state_d     = ST_EXEC;
        end else begin
          new_err  = 1'b1;
          new_code = ERR_ILLEGAL;
          retire   = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_EXEC: begin
        if (unit_done) begin
          // Done beats a coincident timeout.
          mem_start_d = 1'b0;
          alu_start_d = 1'b0;
          retire      = 1'b1;
          state_d     = ST_IDLE;
        end else if (timeout_hit) begin
          mem_start_d = 1'b0;
          alu_start_d = 1'b0;
          tcnt_d      = tcnt_inc;
          new_err     = 1'b1;
          new_code    = ERR_TIMEOUT;
          retire      = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tcnt_d  = tcnt_inc;
          state_d = ST_EXEC;
        end
      end

      default: begin
        mem_start_d = 1'b0;
        alu_start_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Sticky error (first error kept until cleared; new error beats clear),
  // retired counter and busy indication.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    retired_d  = retired_q;
    busy_d     = busy_q;
    if (new_err) begin
      err_d = 1'b1;
      if (clr_err || (err_code_q == ERR_NONE)) begin
        err_code_d = new_code;
      end else begin
        err_code_d = err_code_q;
      end
    end else if (clr_err) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
    busy_d = (state_d != ST_IDLE) || (count_d != (PW+1)'(0));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      sel_mem_q   <= 1'b0;
      tcnt_q      <= '0;
      mem_start_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      retired_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      instr_q     <= instr_d;
      sel_mem_q   <= sel_mem_d;
      tcnt_q      <= tcnt_d;
      mem_start_q <= mem_start_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      alu_start_q <= alu_start_d;
      alu_op_q    <= alu_op_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      retired_q   <= retired_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_start = mem_start_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign retired   = retired_q;
  assign busy      = busy_q;

endmodule
